dmem_arbiter: RTL and testbench

//  Shares the single-port data SRAM (sram0) between two requesters: the core LOAD/STORE port and a DMA/debug port.

---
 rtl/dmem_arbiter_pkg.sv | 11 +
 rtl/dmem_arb_pick.sv | 27 ++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Owner encoding shared by the data-memory arbiter and its priority picker.
// Pure definitions; no logic or state.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational priority decision for one SRAM access slot.
// Zero latency; a losing requester is simply not selected and must hold its request.
module dmem_arb_pick
   import dmem_arbiter_pkg::*;
(
   input  logic   core_req,
   input  logic   dma_req,
   input  logic   lock_q,
   input  logic   burst_open,
   input  logic   starve_full,
   output owner_e owner
);

   always_comb begin
      owner = OWN_NONE;
      if (lock_q && burst_open && dma_req) begin
         owner = OWN_DMA;
      end else if (dma_req && starve_full) begin
         owner = OWN_DMA;
      end else if (core_req) begin
         owner = OWN_CORE;
      end else if (dma_req) begin
         owner = OWN_DMA;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port sram0 between the core LOAD/STORE port and the DMA/debug port.
// Grant is same-cycle, read data returns one cycle later; a denied core is stalled, a denied DMA holds its request.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic              dma_lock,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int SW = $clog2(STARVE_LIM + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
   localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);

   logic [SW-1:0] starve_q, starve_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          lock_q, lock_d;
   owner_e        rd_owner_q, rd_owner_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

   owner_e pick_owner;
   owner_e owner;

   dmem_arb_pick u_pick (
      .core_req    (core_req),
      .dma_req     (dma_req),
      .lock_q      (lock_q),
      .burst_open  (burst_q < BURST_MAX),
      .starve_full (starve_q == STARVE_MAX),
      .owner       (pick_owner)
   );

   // Reset overrides the decision so nothing reaches the SRAM while rst is high.
   assign owner      = rst ? OWN_NONE : pick_owner;
   assign core_gnt   = (owner == OWN_CORE);
   assign dma_gnt    = (owner == OWN_DMA);
   assign core_stall = core_req & ~core_gnt;

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (core_gnt) begin
         sram_en    = 1'b1;
         sram_we    = core_we;
         sram_addr  = core_addr;
         sram_wdata = core_wdata;
      end else if (dma_gnt) begin
         sram_en    = 1'b1;
         sram_we    = dma_we;
         sram_addr  = dma_addr;
         sram_wdata = dma_wdata;
      end
   end

   // A granted beat without lock ends the burst, so the next locked run starts from zero.
   always_comb begin
      starve_d = '0;
      if (dma_req && !dma_gnt) begin
         starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
      end
      burst_d = '0;
      if (dma_gnt && dma_lock) begin
         burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;
      end
      lock_d     = dma_gnt & dma_lock;
      rd_owner_d = (sram_en && !sram_we) ? owner : OWN_NONE;
   end

   assign core_rvalid = (rd_owner_q == OWN_CORE) & ~rst;
   assign dma_rvalid  = (rd_owner_q == OWN_DMA) & ~rst;

   always_comb begin
      core_rdata_d = core_rvalid ? sram_rdata : core_rdata_q;
      dma_rdata_d  = dma_rvalid ? sram_rdata : dma_rdata_q;
   end

   assign core_rdata = core_rdata_d;
   assign dma_rdata  = dma_rdata_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q   <= '0;
         burst_q    <= '0;
         lock_q     <= 1'b0;
         rd_owner_q <= OWN_NONE;
      end else begin
         starve_q   <= starve_d;
         burst_q    <= burst_d;
         lock_q     <= lock_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // Returned data is a pure datapath hold register; it keeps its value across reset.
   always_ff @(posedge clk) begin
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector table plus constrained-random traffic against a rule-level arbiter and memory model.
module tb_dmem_arbiter;

   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int SLIM = 4;
   localparam int MB   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req, core_we, core_gnt, core_stall, core_rvalid;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          sram_en, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata, sram_rdata;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(SLIM), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata)
   );

   // sram0 stand-in: registered read, write at the access edge.
   logic [DW-1:0] sram_mem [0:1023];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) sram_mem[sram_addr] <= sram_wdata;
         else         sram_rdata <= sram_mem[sram_addr];
      end
   end

   typedef struct {
      bit          rst;
      bit          creq, cwe;
      logic [AW-1:0] caddr;
      logic [DW-1:0] cwd;
      bit          dreq, dwe, dlk;
      logic [AW-1:0] daddr;
      logic [DW-1:0] dwd;
      bit          e_cg, e_dg, e_crv, e_drv;
      logic [DW-1:0] e_rd;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: counts of consecutive events, owner of the pending read, shadow memory.
   int            m_starve, m_burst, m_rdown;
   bit            m_lock;
   logic [DW-1:0] smem [0:1023];
   bit            swr  [0:1023];
   logic [DW-1:0] m_pend;
   bit            m_pend_ok;
   logic [DW-1:0] e_crd, e_drd;
   bit            e_crd_ok = 1'b0, e_drd_ok = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(bit r, bit creq, bit cwe, int caddr, int cwd,
                               bit dreq, bit dwe, bit dlk, int daddr, int dwd,
                               bit ecg, bit edg, bit ecrv, bit edrv, int erd);
      vec_t v;
      v.rst = r; v.creq = creq; v.cwe = cwe; v.caddr = AW'(caddr); v.cwd = DW'(cwd);
      v.dreq = dreq; v.dwe = dwe; v.dlk = dlk; v.daddr = AW'(daddr); v.dwd = DW'(dwd);
      v.e_cg = ecg; v.e_dg = edg; v.e_crv = ecrv; v.e_drv = edrv; v.e_rd = DW'(erd);
      return v;
   endfunction

   task automatic run_cycle(input vec_t v, input bit tab, output int own);
      bit crv, drv;
      rst = v.rst;
      core_req = v.creq; core_we = v.cwe; core_addr = v.caddr; core_wdata = v.cwd;
      dma_req = v.dreq; dma_we = v.dwe; dma_lock = v.dlk; dma_addr = v.daddr; dma_wdata = v.dwd;
      #3;
      own = 0;
      if (!v.rst) begin
         if (m_lock && m_burst < MB && v.dreq) own = 2;
         else if (v.dreq && m_starve == SLIM)  own = 2;
         else if (v.creq)                      own = 1;
         else if (v.dreq)                      own = 2;
      end
      crv = !v.rst && m_rdown == 1;
      drv = !v.rst && m_rdown == 2;
      if (crv) begin e_crd = m_pend; e_crd_ok = m_pend_ok; end
      if (drv) begin e_drd = m_pend; e_drd_ok = m_pend_ok; end

      chk("core_gnt", core_gnt, own == 1);
      chk("dma_gnt", dma_gnt, own == 2);
      chk("core_stall", core_stall, v.creq && own != 1);
      chk("sram_en", sram_en, own != 0);
      if (own == 1) chk("sram_core_mux", {sram_we, sram_addr, sram_wdata}, {v.cwe, v.caddr, v.cwd});
      if (own == 2) chk("sram_dma_mux", {sram_we, sram_addr, sram_wdata}, {v.dwe, v.daddr, v.dwd});
      chk("core_rvalid", core_rvalid, crv);
      chk("dma_rvalid", dma_rvalid, drv);
      if (e_crd_ok) chk("core_rdata", core_rdata, e_crd);
      if (e_drd_ok) chk("dma_rdata", dma_rdata, e_drd);
      if (tab) begin
         chk("tab_core_gnt", core_gnt, v.e_cg);
         chk("tab_dma_gnt", dma_gnt, v.e_dg);
         chk("tab_core_rvalid", core_rvalid, v.e_crv);
         chk("tab_dma_rvalid", dma_rvalid, v.e_drv);
         if (v.e_crv) chk("tab_core_rdata", core_rdata, v.e_rd);
         if (v.e_drv) chk("tab_dma_rdata", dma_rdata, v.e_rd);
      end

      if (v.rst) begin
         m_starve = 0; m_burst = 0; m_lock = 0; m_rdown = 0;
      end else begin
         m_starve = (v.dreq && own != 2) ? ((m_starve < SLIM) ? m_starve + 1 : SLIM) : 0;
         m_burst  = (own == 2 && v.dlk) ? ((m_burst < MB) ? m_burst + 1 : MB) : 0;
         m_lock   = (own == 2) && v.dlk;
         m_rdown  = 0;
         if (own != 0) begin
            bit            we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            we = (own == 1) ? v.cwe : v.dwe;
            a  = (own == 1) ? v.caddr : v.daddr;
            d  = (own == 1) ? v.cwd : v.dwd;
            if (we) begin
               smem[a] = d; swr[a] = 1'b1;
            end else begin
               m_rdown = own; m_pend = smem[a]; m_pend_ok = swr[a];
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tab_v [$];
   vec_t v;
   int   own;
   bit   cp, dp;

   initial begin
      for (int i = 0; i < 1024; i++) swr[i] = 1'b0;
      m_starve = 0; m_burst = 0; m_lock = 0; m_rdown = 0; m_pend = '0; m_pend_ok = 0;

      // reset, core store/load round trip
      tab_v.push_back(mk(1, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0));
      tab_v.push_back(mk(0, 1,1,200,'h1234,      0,0,0,0,0,                  1,0,0,0,0));
      tab_v.push_back(mk(0, 1,0,200,0,           0,0,0,0,0,                  1,0,0,0,0));
      tab_v.push_back(mk(0, 0,0,0,0,             0,0,0,0,0,                  0,0,1,0,'h1234));
      // contention: four core grants, then starvation forces the DMA in
      for (int i = 0; i < 4; i++)
         tab_v.push_back(mk(0, 1,1,1,10,         1,1,0,600,'h80000000,       1,0,0,0,0));
      tab_v.push_back(mk(0, 1,1,1,10,            1,1,0,600,'h80000000,       0,1,0,0,0));
      tab_v.push_back(mk(0, 1,1,1,10,            0,0,0,0,0,                  1,0,0,0,0));
      // read steering: DMA load then core load
      tab_v.push_back(mk(0, 0,0,0,0,             1,0,0,600,0,                0,1,0,0,0));
      tab_v.push_back(mk(0, 1,0,1,0,             0,0,0,0,0,                  1,0,0,1,'h80000000));
      tab_v.push_back(mk(0, 0,0,0,0,             0,0,0,0,0,                  0,0,1,0,10));
      // locked burst: starvation entry, 3 locked beats, core preempts, DMA resumes
      for (int i = 0; i < 4; i++)
         tab_v.push_back(mk(0, 1,1,5,7,          1,1,1,700,'h55,             1,0,0,0,0));
      for (int i = 0; i < 4; i++)
         tab_v.push_back(mk(0, 1,1,5,7,          1,1,1,700,'h55,             0,1,0,0,0));
      tab_v.push_back(mk(0, 1,1,5,7,             1,1,1,700,'h55,             1,0,0,0,0));
      tab_v.push_back(mk(0, 0,0,0,0,             1,1,1,700,'h55,             0,1,0,0,0));
      tab_v.push_back(mk(0, 0,0,0,0,             1,1,1,700,'h55,             0,1,0,0,0));
      // reset right after a granted core load drops the return
      tab_v.push_back(mk(0, 1,0,1,0,             0,0,0,0,0,                  1,0,0,0,0));
      tab_v.push_back(mk(1, 1,0,1,0,             1,0,0,600,0,                0,0,0,0,0));
      tab_v.push_back(mk(0, 0,0,0,0,             0,0,0,0,0,                  0,0,0,0,0));
      for (int i = 0; i < 4; i++)
         tab_v.push_back(mk(0, 1,1,1,10,         1,1,0,600,'h80000000,       1,0,0,0,0));
      tab_v.push_back(mk(0, 0,0,0,0,             1,1,0,600,'h80000000,       0,1,0,0,0));
      // idle
      for (int i = 0; i < 20; i++)
         tab_v.push_back(mk(0, 0,0,0,0,          0,0,0,0,0,                  0,0,0,0,0));

      foreach (tab_v[i]) run_cycle(tab_v[i], 1'b1, own);

      // random traffic honouring the hold-until-granted handshake
      cp = 0; dp = 0;
      v = mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
      for (int n = 0; n < 3000; n++) begin
         v.rst = ($urandom_range(0, 99) == 0);
         if (!cp && $urandom_range(0, 3) != 0) begin
            cp = 1; v.cwe = 1'($urandom); v.caddr = AW'($urandom_range(0, 15)); v.cwd = $urandom;
         end
         if (!dp && $urandom_range(0, 2) != 0) begin
            dp = 1; v.dwe = 1'($urandom); v.daddr = AW'($urandom_range(0, 15)); v.dwd = $urandom;
            v.dlk = ($urandom_range(0, 2) != 0);
         end
         v.creq = cp; v.dreq = dp;
         run_cycle(v, 1'b0, own);
         if (own == 1) cp = 0;
         if (own == 2) dp = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
